nibble_serial_accumulator: RTL

//  Downstream consumer of the 4-bit adder. Sums a stream of 4-bit samples into a wide

---
 rtl/nibble_serial_accumulator_pkg.sv | 19 +
 rtl/nibble_serial_accumulator_if.sv | 25 ++
 rtl/nibble_serial_accumulator_adder.sv | 13 +
 rtl/nibble_serial_accumulator.sv | 97 +++++++++
 4 files changed

// File: rtl/nibble_serial_accumulator_pkg.sv
// rtl/nibble_serial_accumulator_pkg.sv - shared constants, FSM states and index-width helper (package nsa_pkg)
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_e;

    // Width of the nibble index; never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/nibble_serial_accumulator_if.sv
// rtl/nibble_serial_accumulator_if.sv - sample handshake and result bundle with master/slave views
interface nibble_serial_accumulator_if #(
    parameter int NIBBLES = 4
);
    import nsa_pkg::*;

    logic                        in_valid;
    logic                        in_ready;
    logic [NIBBLE_W-1:0]         in_data;
    logic                        clear;
    logic [NIBBLE_W*NIBBLES-1:0] acc;
    logic                        acc_valid;
    logic                        overflow;

    modport master (
        output in_valid, in_data, clear,
        input  in_ready, acc, acc_valid, overflow
    );

    modport slave (
        input  in_valid, in_data, clear,
        output in_ready, acc, acc_valid, overflow
    );

endinterface

// File: rtl/nibble_serial_accumulator_adder.sv
// rtl/nibble_serial_accumulator_adder.sv - four_bit_adder, the single nibble add shared across cycles
module four_bit_adder
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    output logic [NIBBLE_W-1:0] sum_o,
    output logic                carry_o
);

    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/nibble_serial_accumulator.sv
// rtl/nibble_serial_accumulator.sv - nibble-serial wide accumulator; NSA_SATURATE_EN selects saturate instead of wrap
module nibble_serial_accumulator
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    nibble_serial_accumulator_if.slave   bus
);

    localparam int ACC_W = NIBBLE_W * NIBBLES;
    localparam int IDX_W = clog2(NIBBLES);
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NIBBLES - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     k_q, k_d;
    logic [NIBBLE_W-1:0]  operand_q, operand_d;
    logic                 carry_q, carry_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic                 overflow_q, overflow_d;

    logic [NIBBLE_W-1:0]  add_a, add_b, add_s;
    logic                 add_c;

    // Nibble 0 adds the sample; higher nibbles only absorb the rippling carry.
    assign add_a = acc_q[k_q*NIBBLE_W +: NIBBLE_W];
    assign add_b = (k_q == '0) ? operand_q : {{(NIBBLE_W-1){1'b0}}, carry_q};

    four_bit_adder u_adder (
        .a_i     (add_a),
        .b_i     (add_b),
        .sum_o   (add_s),
        .carry_o (add_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            operand_q  <= '0;
            carry_q    <= 1'b0;
            acc_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            operand_q  <= operand_d;
            carry_q    <= carry_d;
            acc_q      <= acc_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        operand_d  = operand_q;
        carry_d    = carry_q;
        acc_d      = acc_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (bus.clear) begin
                    acc_d      = '0;
                    overflow_d = 1'b0;
                end else if (bus.in_valid) begin
                    operand_d = bus.in_data;
                    k_d       = '0;
                    state_d   = ADD;
                end
            end
            ADD: begin
                acc_d[k_q*NIBBLE_W +: NIBBLE_W] = add_s;
                carry_d = add_c;
                if (!add_c) begin
                    state_d = IDLE;
                end else if (k_q != K_LAST) begin
                    k_d = k_q + 1'b1;
                end else begin
                    overflow_d = 1'b1;
                    state_d    = IDLE;
`ifdef NSA_SATURATE_EN
                    acc_d      = '1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE) && !bus.clear;
    assign bus.acc_valid = (state_q == IDLE);
    assign bus.acc       = acc_q;
    assign bus.overflow  = overflow_q;

endmodule
